// File: rtl/write_resp_arbiter.sv
// Write-response arbiter: round-robin merge of two slave-side B channels into
// a single-entry holding register that feeds the master-side response decoder.
// Responses carrying an ID outside the legal master range are consumed and
// flagged with Resp_Drop instead of being forwarded.
module write_resp_arbiter #(
    parameter int unsigned Num_Of_Masters = 2,
    parameter int unsigned ID_Width       = 2
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                M00_AXI_bvalid,
    input  logic [1:0]          M00_AXI_bresp,
    input  logic [ID_Width-1:0] M00_AXI_bid,
    output logic                M00_AXI_bready,
    input  logic                M01_AXI_bvalid,
    input  logic [1:0]          M01_AXI_bresp,
    input  logic [ID_Width-1:0] M01_AXI_bid,
    output logic                M01_AXI_bready,
    input  logic                S00_AXI_bready,
    input  logic                S01_AXI_bready,
    input  logic                S02_AXI_bready,
    input  logic                S03_AXI_bready,
    output logic [ID_Width-1:0] Sel_Resp_ID,
    output logic [1:0]          Sel_Write_Resp,
    output logic                Sel_Valid,
    output logic                Resp_Drop,
    output logic [15:0]         Resp_Count
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                rr_m01_last;   // 1: M01 granted last, so M00 wins a tie
    logic [3:0]          s_ready;
    logic                master_ready;
    logic                handshake;
    logic                capture_opp;
    logic                grant0;
    logic                grant1;
    logic                capture;
    logic                cap_legal;
    logic [ID_Width-1:0] cap_id;
    logic [1:0]          cap_resp;

    assign s_ready = {S03_AXI_bready, S02_AXI_bready, S01_AXI_bready, S00_AXI_bready};

    // Ready of the destination master; ports beyond the configured count never count.
    always_comb begin
        master_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < Num_Of_Masters && 32'(Sel_Resp_ID) == i) begin
                master_ready = s_ready[i];
            end
        end
    end

    // Handshake detection, round-robin grant, capture mux and next state.
    always_comb begin
        handshake   = (state == BUSY) && master_ready;
        capture_opp = (state == IDLE) || handshake;
        // ARESETN gating keeps both bready low while reset is held
        grant0      = ARESETN && capture_opp && M00_AXI_bvalid &&
                      (!M01_AXI_bvalid || rr_m01_last);
        grant1      = ARESETN && capture_opp && M01_AXI_bvalid &&
                      (!M00_AXI_bvalid || !rr_m01_last);
        capture     = grant0 || grant1;
        cap_id      = grant1 ? M01_AXI_bid   : M00_AXI_bid;
        cap_resp    = grant1 ? M01_AXI_bresp : M00_AXI_bresp;
        cap_legal   = 32'(cap_id) < Num_Of_Masters;
        state_nxt   = state;
        if (capture && cap_legal) begin
            state_nxt = BUSY;
        end else if (capture || handshake) begin
            state_nxt = IDLE;
        end
    end

    assign M00_AXI_bready = grant0;
    assign M01_AXI_bready = grant1;
    assign Sel_Valid      = (state == BUSY);

    // State, holding register, drop pulse, handshake counter and RR pointer.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state          <= IDLE;
            Sel_Resp_ID    <= '0;
            Sel_Write_Resp <= '0;
            Resp_Drop      <= 1'b0;
            Resp_Count     <= '0;
            rr_m01_last    <= 1'b1;
        end else begin
            state     <= state_nxt;
            Resp_Drop <= capture && !cap_legal;
            if (capture && cap_legal) begin
                Sel_Resp_ID    <= cap_id;
                Sel_Write_Resp <= cap_resp;
            end
            if (handshake) begin
                Resp_Count <= Resp_Count + 16'd1;
            end
            if (capture) begin
                rr_m01_last <= grant1;
            end
        end
    end

endmodule

// File: tb/tb_write_resp_arbiter.sv
// Bench for write_resp_arbiter: hand-derived vector table, corner-case
// sequences and randomized traffic, all checked against a behavioural model.
module tb_write_resp_arbiter;

    localparam int NUM_M = 2;

    logic       clk;
    logic       rst_n;
    logic       v0, v1;
    logic [1:0] id0, id1, r0, r1;
    logic [3:0] sready;
    logic       br0, br1;
    logic [1:0] sel_id;
    logic [1:0] sel_resp;
    logic       sel_valid;
    logic       drop;
    logic [15:0] cnt;

    write_resp_arbiter #(.Num_Of_Masters(NUM_M), .ID_Width(2)) dut (
        .ACLK           (clk),
        .ARESETN        (rst_n),
        .M00_AXI_bvalid (v0),
        .M00_AXI_bresp  (r0),
        .M00_AXI_bid    (id0),
        .M00_AXI_bready (br0),
        .M01_AXI_bvalid (v1),
        .M01_AXI_bresp  (r1),
        .M01_AXI_bid    (id1),
        .M01_AXI_bready (br1),
        .S00_AXI_bready (sready[0]),
        .S01_AXI_bready (sready[1]),
        .S02_AXI_bready (sready[2]),
        .S03_AXI_bready (sready[3]),
        .Sel_Resp_ID    (sel_id),
        .Sel_Write_Resp (sel_resp),
        .Sel_Valid      (sel_valid),
        .Resp_Drop      (drop),
        .Resp_Count     (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a holding slot (queue of at most one), who won last,
    // and a running handshake total.
    typedef struct {
        int id;
        int resp;
    } resp_t;

    resp_t m_held[$];
    int    m_last;     // port granted last: 0 or 1
    int    m_total;
    int    m_drop;

    task automatic model_reset();
        m_held.delete();
        m_last  = 1;
        m_total = 0;
        m_drop  = 0;
    endtask

    // One cycle: drive inputs after the falling edge, check bready mid-cycle,
    // advance the model at the rising edge and check registered outputs after.
    task automatic step(input logic a_v0, input int a_id0, input int a_r0,
                        input logic a_v1, input int a_id1, input int a_r1,
                        input logic [3:0] a_sr,
                        output logic o_br0, output logic o_br1);
        bit    hs;
        int    pick;
        resp_t nw;
        v0 = a_v0; id0 = 2'(a_id0); r0 = 2'(a_r0);
        v1 = a_v1; id1 = 2'(a_id1); r1 = 2'(a_r1);
        sready = a_sr;
        #1;
        hs = 0;
        if (m_held.size() != 0)
            hs = (m_held[0].id < NUM_M) && a_sr[m_held[0].id];
        pick = -1;
        if (m_held.size() == 0 || hs) begin
            if (a_v0 && a_v1) pick = (m_last == 1) ? 0 : 1;
            else if (a_v0)    pick = 0;
            else if (a_v1)    pick = 1;
        end
        o_br0 = br0;
        o_br1 = br1;
        chk("m00_bready", int'(br0), int'(pick == 0));
        chk("m01_bready", int'(br1), int'(pick == 1));
        @(posedge clk);
        if (hs) begin
            m_total = (m_total + 1) % 65536;
            void'(m_held.pop_front());
        end
        m_drop = 0;
        if (pick >= 0) begin
            m_last  = pick;
            nw.id   = (pick == 0) ? a_id0 : a_id1;
            nw.resp = (pick == 0) ? a_r0  : a_r1;
            if (nw.id < NUM_M) m_held.push_back(nw);
            else               m_drop = 1;
        end
        #1;
        chk("sel_valid", int'(sel_valid), int'(m_held.size() != 0));
        chk("resp_drop", int'(drop), m_drop);
        chk("resp_count", int'(cnt), m_total);
        if (m_held.size() != 0) begin
            chk("sel_resp_id", int'(sel_id), m_held[0].id);
            chk("sel_write_resp", int'(sel_resp), m_held[0].resp);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic       v0;
        int         id0;
        int         r0;
        logic       v1;
        int         id1;
        int         r1;
        logic [3:0] sr;
        logic       e_br0;
        logic       e_br1;
        logic       e_valid;
        int         e_id;
        int         e_resp;
        logic       e_drop;
        int         e_cnt;
    } vec_t;

    vec_t       tbl[12];
    logic       b0, b1;
    logic [1:0] held_id, held_resp;
    int         bound;

    initial begin
        // v0 id0 r0 v1 id1 r1 sready | br0 br1 valid id resp drop cnt
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 0, 4'b0010, 1, 0, 1, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{1, 0, 2, 1, 1, 1, 4'b0000, 0, 1, 1, 1, 1, 0, 1};
        tbl[4]  = '{1, 0, 2, 1, 1, 1, 4'b0001, 0, 0, 1, 1, 1, 0, 1};
        tbl[5]  = '{1, 0, 2, 1, 1, 1, 4'b0010, 1, 0, 1, 0, 2, 0, 2};
        tbl[6]  = '{0, 0, 0, 1, 3, 3, 4'b0001, 0, 1, 0, 0, 0, 1, 3};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 3};
        tbl[8]  = '{0, 0, 0, 1, 2, 0, 4'b1111, 0, 1, 0, 0, 0, 1, 3};
        tbl[9]  = '{1, 0, 3, 0, 0, 0, 4'b1100, 1, 0, 1, 0, 3, 0, 3};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 4'b1100, 0, 0, 1, 0, 3, 0, 3};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 4};

        v0 = 0; v1 = 0; id0 = '0; id1 = '0; r0 = '0; r1 = '0; sready = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_sel_valid", int'(sel_valid), 0);
        chk("reset_sel_id", int'(sel_id), 0);
        chk("reset_sel_resp", int'(sel_resp), 0);
        chk("reset_count", int'(cnt), 0);
        chk("reset_drop", int'(drop), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Hand-derived vector table, applied back to back from reset.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v0, tbl[i].id0, tbl[i].r0, tbl[i].v1, tbl[i].id1, tbl[i].r1,
                 tbl[i].sr, b0, b1);
            chk($sformatf("tbl%0d_br0", i), int'(b0), int'(tbl[i].e_br0));
            chk($sformatf("tbl%0d_br1", i), int'(b1), int'(tbl[i].e_br1));
            chk($sformatf("tbl%0d_valid", i), int'(sel_valid), int'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_drop", i), int'(drop), int'(tbl[i].e_drop));
            chk($sformatf("tbl%0d_cnt", i), int'(cnt), tbl[i].e_cnt);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_id", i), int'(sel_id), tbl[i].e_id);
                chk($sformatf("tbl%0d_resp", i), int'(sel_resp), tbl[i].e_resp);
            end
        end

        // Stall: held id0/SLVERR with S00 not ready, S01 toggling, both slaves valid.
        step(1, 0, 2, 0, 0, 0, 4'b0000, b0, b1);
        held_id = sel_id;
        held_resp = sel_resp;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 1, 1, 0, (i % 2 == 0) ? 4'b0010 : 4'b0000, b0, b1);
            chk("stall_br0", int'(b0), 0);
            chk("stall_br1", int'(b1), 0);
            chk("stall_valid", int'(sel_valid), 1);
            chk("stall_id", int'(sel_id), int'(held_id));
            chk("stall_resp", int'(sel_resp), int'(held_resp));
        end

        // Both slaves valid, masters always ready: grants must alternate.
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 1, 1, 1, 4'b0011, b0, b1);
            chk("alt_one_grant", int'(b0) + int'(b1), 1);
            chk("alt_valid", int'(sel_valid), 1);
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 4'($urandom), b0, b1);
        end

        // Asynchronous reset mid-BUSY, away from any clock edge.
        step(0, 0, 0, 0, 0, 0, 4'b0011, b0, b1);
        step(1, 1, 2, 0, 0, 0, 4'b0000, b0, b1);
        chk("pre_reset_valid", int'(sel_valid), 1);
        #2;
        v0 = 1; v1 = 1;
        rst_n = 1'b0;
        #1;
        chk("async_sel_valid", int'(sel_valid), 0);
        chk("async_count", int'(cnt), 0);
        chk("async_br0", int'(br0), 0);
        chk("async_br1", int'(br1), 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("held_rst_valid", int'(sel_valid), 0);
        chk("held_rst_br0", int'(br0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 1, 1, 1, 2, 4'b0000, b0, b1);
        chk("post_rst_m00_first", int'(b0), 1);
        chk("post_rst_m01_not", int'(b1), 0);
        chk("post_rst_id", int'(sel_id), 0);

        // Counter wrap: sustained M00 traffic to master 0 until 0xFFFF, then once more.
        bound = 0;
        while (m_total != 65535 && bound < 70000) begin
            step(1, 0, 0, 0, 0, 0, 4'b0001, b0, b1);
            bound++;
        end
        chk("wrap_reached_in_bound", int'(bound < 70000), 1);
        chk("count_ffff", int'(cnt), 65535);
        step(1, 0, 0, 0, 0, 0, 4'b0001, b0, b1);
        chk("count_wrap_zero", int'(cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_resp_arbiter.md
WRITE_RESP_ARBITER -- requirements
Module: write_resp_arbiter

Interface
REQ-001 Parameter Num_Of_Masters, default 2: number of master ports that can legally receive a response (IDs 0..Num_Of_Masters-1).
REQ-002 Parameter ID_Width, default 2: width of all response-ID fields.
REQ-003 ACLK  input  1  clock; all state updates on its rising edge.
REQ-004 ARESETN  input  1  reset; asynchronous assert, active-low.
REQ-005 M00_AXI_bvalid / M01_AXI_bvalid  input  1 each  slave-side write-response valid.
REQ-006 M00_AXI_bresp / M01_AXI_bresp  input  2 each  slave-side write response.
REQ-007 M00_AXI_bid / M01_AXI_bid  input  ID_Width each  destination master ID.
REQ-008 M00_AXI_bready / M01_AXI_bready  output  1 each  slave-side accept.
REQ-009 S00_AXI_bready..S03_AXI_bready  input  1 each  master-side ready; bits at index >= Num_Of_Masters ignored.
REQ-010 Sel_Resp_ID  output  ID_Width  selected destination ID to the response decoder.
REQ-011 Sel_Write_Resp  output  2  selected response to the decoder.
REQ-012 Sel_Valid  output  1  selected response valid.
REQ-013 Resp_Drop  output  1  one-cycle pulse: response with illegal ID consumed.
REQ-014 Resp_Count  output  16  completed master-side handshakes, wraps at 0xFFFF->0.

Function
REQ-015 Two states: IDLE (holding register empty, Sel_Valid=0) and BUSY (holding register full, Sel_Valid=1).
REQ-016 Capture opportunity: any cycle in IDLE, or a BUSY cycle in which the master handshake completes.
REQ-017 Arbitration at a capture opportunity: round-robin between M00 and M01; with both valid, grant goes to the port not granted last; after reset, M00 has priority.
REQ-018 Granted port sees Mxx_AXI_bready=1 combinationally in the capture cycle only; the non-granted port sees 0; no bready without the matching bvalid.
REQ-019 On capture of a legal ID (< Num_Of_Masters): bid and bresp are registered into Sel_Resp_ID and Sel_Write_Resp, and the state is BUSY next cycle.
REQ-020 On capture of an illegal ID (>= Num_Of_Masters): the response is consumed and discarded; Resp_Drop=1 the next cycle; Resp_Count is unchanged.
REQ-021 After an illegal-ID capture: the state becomes IDLE, or stays IDLE; the round-robin pointer still advances.
REQ-022 Master handshake: in BUSY, handshake occurs when S[Sel_Resp_ID]_AXI_bready=1.
REQ-023 Handshake effects: Resp_Count increments by 1 next edge; with no capture in the same cycle, the state becomes IDLE.
REQ-024 Back-to-back: handshake plus a legal capture in the same cycle keeps the state BUSY with new contents, giving one response per cycle sustained.
REQ-025 While BUSY without handshake: Sel_Resp_ID, Sel_Write_Resp and Sel_Valid are held stable; both Mxx_AXI_bready are 0.
REQ-026 Sel_Write_Resp is passed unmodified (OKAY/EXOKAY/SLVERR/DECERR); no response is generated or altered.
REQ-027 All outputs except Mxx_AXI_bready are registered.

Reset
REQ-028 On ARESETN=0, immediately and for as long as it is held: state=IDLE, Sel_Valid=0, Sel_Resp_ID=0, Sel_Write_Resp=0, Resp_Drop=0, Resp_Count=0, RR pointer favors M00, both Mxx_AXI_bready=0.
REQ-029 Reset asserted while BUSY discards the held response with no handshake; the first capture after release follows REQ-017.

Verification
REQ-030 Scenario: M00 valid with bid=1, bresp=2'b00, S01 ready=1 -> M00 bready=1 for 1 cycle; next cycle Sel_Valid=1, Sel_Resp_ID=1; handshake occurs; then Sel_Valid=0; Resp_Count=1.
REQ-031 Scenario: M00 and M01 both valid continuously, destination masters always ready -> grants alternate M00, M01, M00...; Sel_Valid stays 1; Resp_Count +1 per cycle.
REQ-032 Scenario: BUSY with bid=0, bresp=2'b10, S00 ready=0 for 5 cycles -> outputs stable 5 cycles; both bready=0; S01 ready toggling has no effect.
REQ-033 Scenario: M01 bid=3 with Num_Of_Masters=2 -> M01 bready=1 for one cycle; Resp_Drop=1 next cycle; Sel_Valid stays 0; Resp_Count unchanged.
REQ-034 Scenario: Resp_Count preloaded to 0xFFFF via 65535 handshakes, then one more handshake -> Resp_Count=0x0000.
REQ-035 Scenario: ARESETN pulsed low mid-BUSY, asynchronous to ACLK -> Sel_Valid=0 without waiting for an ACLK edge; after release, simultaneous M00 and M01 valid -> M00 granted first.
